// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array job sequencer: state encoding and
// helpers that size the step counter and the drained-row index.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Step counter must reach K+ROWS+COLS-2 at K=2^KW-1 without wrapping.
  function automatic int cnt_width(input int kw, input int rows, input int cols);
    return kw + $clog2(rows + cols) + 1;
  endfunction

  function automatic int row_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

  localparam int CNT_W = cnt_width(8, 4, 4);
  localparam int ROW_W = row_width(4);

endpackage

// File: rtl/systolic_array_ctrl_skew_lane_gen.sv
// One operand feeder lane: valid while offset <= t < offset+K, index t-offset.
module skew_lane_gen #(
  parameter int KW  = 8,
  parameter int CW  = 12,
  parameter int OFS = 0
) (
  input  logic [CW-1:0] t,
  input  logic [KW-1:0] k,
  input  logic          active,
  output logic          valid,
  output logic [KW-1:0] idx
);

  localparam logic [CW-1:0] OFS_C = CW'(OFS);

  logic [CW-1:0] rel;
  logic          in_window;

  always_comb begin
    rel       = t - OFS_C;
    in_window = (t >= OFS_C) && (rel < CW'(k));
    valid     = active && in_window;
    idx       = valid ? rel[KW-1:0] : '0;
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an output-stationary PE grid: clear, skewed operand
// streaming, accumulator drain down the B/Bout chain, completion pulse.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   pe_clr,
  output logic                   pe_read,
  output logic                   pe_write,
  output logic [ROWS-1:0]        a_valid,
  output logic [ROWS*KW-1:0]     a_idx,
  output logic [COLS-1:0]        b_valid,
  output logic [COLS*KW-1:0]     b_idx,
  output logic                   out_valid,
  output logic [$clog2(ROWS):0]  out_row
);

  localparam int CW = cnt_width(KW, ROWS, COLS);
  localparam int RW = row_width(ROWS);

  localparam logic [CW-1:0] SPAN   = CW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] LAST_D = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROWS_C = RW'(ROWS);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] t_q, t_d, t_last;
  logic [RW-1:0] d_q, d_d;

  logic               busy_d, done_d, clr_d, read_d, write_d, ov_d, computing_d;
  logic [RW-1:0]      row_d;
  logic [ROWS-1:0]    av_d;
  logic [ROWS*KW-1:0] ai_d;
  logic [COLS-1:0]    bv_d;
  logic [COLS*KW-1:0] bi_d;

  // Only evaluated when K>0, so subtracting one cannot underflow.
  assign t_last = CW'(k_q) + SPAN - CW'(1);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      t_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          t_d     = '0;
          d_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        t_d     = '0;
        d_d     = '0;
        state_d = (k_q != '0) ? COMPUTE : DRAIN;
      end
      COMPUTE: begin
        if (t_q == t_last) begin
          d_d     = '0;
          state_d = DRAIN;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      DRAIN: begin
        if (d_q == LAST_D) begin
          state_d = DONE;
        end else begin
          d_d = d_q + RW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // and still line up with the state they describe.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    clr_d       = (state_d == CLEAR);
    write_d     = (state_d == DRAIN);
    read_d      = (state_d == DRAIN) && (d_d != '0);
    computing_d = (state_d == COMPUTE);
    ov_d        = read_d || done_d;
    row_d       = '0;
    if (read_d) begin
      row_d = ROWS_C - d_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row_lane
    skew_lane_gen #(.KW(KW), .CW(CW), .OFS(r)) u_lane (
      .t      (t_d),
      .k      (k_d),
      .active (computing_d),
      .valid  (av_d[r]),
      .idx    (ai_d[r*KW +: KW])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_lane
    skew_lane_gen #(.KW(KW), .CW(CW), .OFS(c)) u_lane (
      .t      (t_d),
      .k      (k_d),
      .active (computing_d),
      .valid  (bv_d[c]),
      .idx    (bi_d[c*KW +: KW])
    );
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pe_clr    <= 1'b0;
      pe_read   <= 1'b0;
      pe_write  <= 1'b0;
      a_valid   <= '0;
      a_idx     <= '0;
      b_valid   <= '0;
      b_idx     <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      pe_clr    <= clr_d;
      pe_read   <= read_d;
      pe_write  <= write_d;
      a_valid   <= av_d;
      a_idx     <= ai_d;
      b_valid   <= bv_d;
      b_idx     <= bi_d;
      out_valid <= ov_d;
      out_row   <= row_d;
    end
  end

endmodule
